// File: rtl/lynx_pkg.sv
// Shared types and constants for the Lynx video-bank arbiter slice.
package lynx_pkg;

  localparam int VRAM_AW       = 15;
  localparam int VRAM_BANK_BIT = 14;

  typedef enum logic [1:0] {IDLE, ISSUE, WAITD, DONE} arb_state_t;
  typedef enum logic {OWN_VID, OWN_CPU} owner_t;

endpackage

// File: rtl/lynx_arb_prio.sv
// Video-priority grant decision with a CPU starvation counter.
// The forced-grant flag exists only when LYNX_VRAM_ARB_STATS_EN is defined.
module lynx_arb_prio
  import lynx_pkg::*;
#(
  parameter int VID_BURST = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic arb_en,
  input  logic vid_req,
  input  logic cpu_req,
  output logic grant_vid,
  output logic grant_cpu
`ifdef LYNX_VRAM_ARB_STATS_EN
  ,
  output logic forced
`endif
);

  localparam logic [3:0] BURST = 4'(VID_BURST);

  logic [3:0] cnt;
  logic       at_limit;

  always_comb begin
    at_limit  = (cnt == BURST);
    grant_vid = arb_en && vid_req && !(cpu_req && at_limit);
    grant_cpu = arb_en && !grant_vid && cpu_req;
  end

`ifdef LYNX_VRAM_ARB_STATS_EN
  // A CPU grant only counts as forced when video was also asking.
  assign forced = grant_cpu && vid_req;
`endif

  // Counts video grants taken while the CPU is kept waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (grant_vid) begin
      if (!cpu_req)      cnt <= '0;
      else if (!at_limit) cnt <= cnt + 4'd1;
    end else if (grant_cpu) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/lynx_vram_arbiter.sv
// Single-port video-bank arbiter: video fetch has priority, CPU gets a bounded-wait slot.
// Define LYNX_VRAM_ARB_STATS_EN to add grant statistics counters.
module lynx_vram_arbiter
  import lynx_pkg::*;
#(
  parameter int AW        = VRAM_AW,
  parameter int MEM_LAT   = 2,
  parameter int VID_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_di,
  output logic          cpu_ack,
  output logic [7:0]    cpu_do,
  output logic          cpu_wait,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_di,
  input  logic [7:0]    mem_do
`ifdef LYNX_VRAM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_vid_cnt,
  output logic [15:0]   stat_cpu_cnt,
  output logic [15:0]   stat_force_cnt
`endif
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);

  arb_state_t    state, state_nxt;
  owner_t        owner_p0;
  logic [AW-1:0] addr_p0;
  logic          we_p0;
  logic [7:0]    di_p0;
  logic [2:0]    wait_cnt;
  logic          arb_en;
  logic          grant_vid;
  logic          grant_cpu;
  logic          capture;
`ifdef LYNX_VRAM_ARB_STATS_EN
  logic          forced;
`endif

  assign arb_en  = (state == IDLE);
  assign capture = (state == WAITD) && (wait_cnt == WAIT_LAST);

  lynx_arb_prio #(
    .VID_BURST (VID_BURST)
  ) u_prio (
    .clock     (clock),
    .reset     (reset),
    .arb_en    (arb_en),
    .vid_req   (vid_req),
    .cpu_req   (cpu_req),
    .grant_vid (grant_vid),
    .grant_cpu (grant_cpu)
`ifdef LYNX_VRAM_ARB_STATS_EN
    ,
    .forced    (forced)
`endif
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // WAITD spans MEM_LAT clocks so the ack lands MEM_LAT+1 clocks after ISSUE.
  always_comb begin
    state_nxt = state;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    vid_ack   = 1'b0;
    cpu_ack   = 1'b0;
    case (state)
      IDLE:  if (grant_vid || grant_cpu) state_nxt = ISSUE;
      ISSUE: begin
        mem_ce    = 1'b1;
        mem_we    = we_p0;
        state_nxt = WAITD;
      end
      WAITD: if (wait_cnt == WAIT_LAST) state_nxt = DONE;
      DONE: begin
        vid_ack   = (owner_p0 == OWN_VID);
        cpu_ack   = (owner_p0 == OWN_CPU);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_wait = cpu_req & ~cpu_ack;
  assign mem_addr = addr_p0;
  assign mem_di   = di_p0;

  // Grant stage: request fields are frozen here; later input changes are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_p0 <= OWN_VID;
      addr_p0  <= '0;
      we_p0    <= 1'b0;
      di_p0    <= '0;
      wait_cnt <= '0;
      vid_data <= '0;
      cpu_do   <= '0;
    end else begin
      if (grant_vid) begin
        owner_p0 <= OWN_VID;
        addr_p0  <= vid_addr;
        we_p0    <= 1'b0;
        di_p0    <= '0;
      end else if (grant_cpu) begin
        owner_p0 <= OWN_CPU;
        addr_p0  <= cpu_addr;
        we_p0    <= cpu_we;
        di_p0    <= cpu_di;
      end
      if (state == ISSUE)      wait_cnt <= '0;
      else if (state == WAITD) wait_cnt <= wait_cnt + 3'd1;
      // Capture stage: read data lands in the owner's register as the ack starts.
      if (capture && !we_p0) begin
        if (owner_p0 == OWN_VID) vid_data <= mem_do;
        else                     cpu_do   <= mem_do;
      end
    end
  end

`ifdef LYNX_VRAM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_vid_cnt   <= '0;
      stat_cpu_cnt   <= '0;
      stat_force_cnt <= '0;
    end else begin
      if (grant_vid) stat_vid_cnt   <= stat_vid_cnt + 16'd1;
      if (grant_cpu) stat_cpu_cnt   <= stat_cpu_cnt + 16'd1;
      if (forced)    stat_force_cnt <= stat_force_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lynx_vram_arbiter.sv
// Randomised bench for lynx_vram_arbiter against a transaction-level timing/data model.
// Also covers LYNX_VRAM_ARB_STATS_EN builds when the macro is defined.
module tb_lynx_vram_arbiter;
  import lynx_pkg::*;

  localparam int AW        = 15;
  localparam int MEM_LAT   = 2;
  localparam int VID_BURST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_ack;
  logic [7:0]    vid_data;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_di = '0;
  logic          cpu_ack;
  logic [7:0]    cpu_do;
  logic          cpu_wait;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_di;
  logic [7:0]    mem_do = '0;
`ifdef LYNX_VRAM_ARB_STATS_EN
  logic [15:0]   stat_vid_cnt, stat_cpu_cnt, stat_force_cnt;
`endif

  lynx_vram_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT), .VID_BURST(VID_BURST)) dut (
    .clock    (clk),
    .reset    (rst),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_ack  (vid_ack),
    .vid_data (vid_data),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_di   (cpu_di),
    .cpu_ack  (cpu_ack),
    .cpu_do   (cpu_do),
    .cpu_wait (cpu_wait),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_di   (mem_di),
    .mem_do   (mem_do)
`ifdef LYNX_VRAM_ARB_STATS_EN
    ,
    .stat_vid_cnt   (stat_vid_cnt),
    .stat_cpu_cnt   (stat_cpu_cnt),
    .stat_force_cnt (stat_force_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return 8'(i) ^ 8'(i >> 7);
  endfunction

  // Memory macro model: returns read data MEM_LAT clocks after the strobe, junk otherwise.
  logic [7:0]    dev_mem [0:(1<<AW)-1];
  bit            dev_init = 0;
  int            rd_cnt = 0;
  logic [7:0]    rd_val;
  logic          ce_n = 0, we_n = 0;
  logic [AW-1:0] addr_n = '0;
  logic [7:0]    di_n = '0;

  always @(posedge clk) begin
    if (!dev_init) begin
      for (int i = 0; i < (1 << AW); i++) dev_mem[i] = init_val(i);
      dev_init = 1;
    end
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) mem_do <= rd_val;
      else             mem_do <= 8'($urandom);
    end else begin
      mem_do <= 8'($urandom);
    end
    if (ce_n) begin
      if (we_n) dev_mem[addr_n] = di_n;
      else begin
        rd_val = dev_mem[addr_n];
        if (MEM_LAT == 1) mem_do <= rd_val;
        else              rd_cnt = MEM_LAT - 1;
      end
    end
  end

  // Reference model: one access at a time, fixed cycle offsets from the grant.
  logic [7:0]    shadow [0:(1<<AW)-1];
  bit            armed = 0;
  bit            quiet = 1;
  int            ce_cyc = -1, ack_cyc = -1, free_at = 0, m_cnt = 0;
  bit            g_vid = 0, g_we = 0;
  logic [AW-1:0] g_addr = '0;
  logic [7:0]    g_di = '0, rd_exp = '0, exp_vid_data = '0, exp_cpu_do = '0;
  logic [15:0]   s_vid = 0, s_cpu = 0, s_frc = 0;
  bit            seen_vid_ack = 0, seen_cpu_ack = 0;
  bit            ack_log [$];

  always @(negedge clk) begin
    bit e_ce, e_vack, e_cack;
    ce_n = mem_ce; we_n = mem_we; addr_n = mem_addr; di_n = mem_di;
    seen_vid_ack = vid_ack;
    seen_cpu_ack = cpu_ack;
    if (vid_ack) ack_log.push_back(1'b0);
    if (cpu_ack) ack_log.push_back(1'b1);
    if (armed) begin
      cyc++;
      e_ce = (cyc == ce_cyc);
      chk("mem_ce", mem_ce, e_ce);
      if (e_ce) begin
        chk("mem_we", mem_we, g_we);
        chk("mem_addr", mem_addr, g_addr);
        if (g_we) begin
          chk("mem_di", mem_di, g_di);
          shadow[g_addr] = g_di;
        end else begin
          rd_exp = shadow[g_addr];
        end
      end
      e_vack = (cyc == ack_cyc) && g_vid;
      e_cack = (cyc == ack_cyc) && !g_vid;
      if (e_vack) exp_vid_data = rd_exp;
      if (e_cack && !g_we) exp_cpu_do = rd_exp;
      chk("vid_ack", vid_ack, e_vack);
      chk("cpu_ack", cpu_ack, e_cack);
      chk("vid_data", vid_data, exp_vid_data);
      chk("cpu_do", cpu_do, exp_cpu_do);
      chk("cpu_wait", cpu_wait, cpu_req && !e_cack);
      if (quiet) begin
        chk("idle_addr", mem_addr, 0);
        chk("idle_di", mem_di, 0);
        chk("idle_we", mem_we, 0);
      end
`ifdef LYNX_VRAM_ARB_STATS_EN
      chk("stat_vid", stat_vid_cnt, s_vid);
      chk("stat_cpu", stat_cpu_cnt, s_cpu);
      chk("stat_force", stat_force_cnt, s_frc);
`endif
    end
    if (rst) begin
      if (!armed) for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(i);
      armed = 1;
      ce_cyc = -1; ack_cyc = -1; free_at = cyc + 1; m_cnt = 0;
      exp_vid_data = 0; exp_cpu_do = 0; quiet = 1;
      s_vid = 0; s_cpu = 0; s_frc = 0;
    end else if (armed && cyc >= free_at && (vid_req || cpu_req)) begin
      if (vid_req && !(cpu_req && m_cnt == VID_BURST)) begin
        g_vid = 1; g_we = 0; g_addr = vid_addr; g_di = 0;
        m_cnt = cpu_req ? ((m_cnt < VID_BURST) ? m_cnt + 1 : m_cnt) : 0;
        s_vid++;
      end else begin
        g_vid = 0; g_we = cpu_we; g_addr = cpu_addr; g_di = cpu_di;
        if (vid_req) s_frc++;
        m_cnt = 0;
        s_cpu++;
      end
      ce_cyc = cyc + 1; ack_cyc = cyc + MEM_LAT + 2; free_at = cyc + MEM_LAT + 3;
      quiet = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    int n;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_di = d; n = 0;
    tick();
    while (!seen_cpu_ack && n < 50) begin tick(); n++; end
    chk("cpu_timeout", n >= 50, 0);
    cpu_req = 0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    a = '0;
    a[VRAM_BANK_BIT] = 1'($urandom);
    a[3:0] = 4'($urandom);
    return a;
  endfunction

  initial begin
    int n0, n, ncpu;
`ifdef LYNX_VRAM_ARB_STATS_EN
    logic [15:0] v0, c0, f0;
`endif
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();

    // Single write then read-back
    cpu_access(1, 15'h2005, 8'hA5);
    cpu_access(0, 15'h2005, 8'h00);
    chk("rdback", cpu_do, 8'hA5);
    repeat (3) tick();
    chk("rdback_hold", cpu_do, 8'hA5);

    // Same-clock requests: video first
    n0 = ack_log.size();
    vid_req = 1; vid_addr = 15'h4010;
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h2005;
    n = 0;
    while ((vid_req || cpu_req) && n < 100) begin
      tick(); n++;
      if (seen_vid_ack) vid_req = 0;
      if (seen_cpu_ack) cpu_req = 0;
    end
    chk("both_timeout", n >= 100, 0);
    chk("both_first_vid", ack_log.size() > n0 ? ack_log[n0] : 1'bx, 0);
    chk("both_then_cpu", ack_log.size() > n0 + 1 ? ack_log[n0+1] : 1'bx, 1);

    // Starvation: both held continuously
`ifdef LYNX_VRAM_ARB_STATS_EN
    v0 = stat_vid_cnt; c0 = stat_cpu_cnt; f0 = stat_force_cnt;
`endif
    n0 = ack_log.size();
    vid_req = 1; cpu_req = 1; ncpu = 0; n = 0;
    while (ncpu < 10 && n < 2000) begin
      tick(); n++;
      if (seen_cpu_ack) ncpu++;
      vid_addr = rnd_addr(); cpu_addr = rnd_addr();
      cpu_we = 1'($urandom); cpu_di = 8'($urandom);
    end
    vid_req = 0; cpu_req = 0;
    chk("starve_timeout", n >= 2000, 0);
    chk("starve_len", ack_log.size() - n0, 10 * (VID_BURST + 1));
    for (int i = 0; i < 10 * (VID_BURST + 1); i++)
      chk("starve_seq", (n0 + i < ack_log.size()) ? ack_log[n0+i] : 1'bx,
          (i % (VID_BURST + 1)) == VID_BURST);
`ifdef LYNX_VRAM_ARB_STATS_EN
    tick();
    chk("stat_force_10", stat_force_cnt - f0, 10);
    chk("stat_cpu_10", stat_cpu_cnt - c0, 10);
    chk("stat_vid_40", stat_vid_cnt - v0, 40);
`endif

    // Reset in WAITD of a CPU read
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h2005; n = 0;
    tick();
    while (!ce_n && n < 50) begin tick(); n++; end
    chk("issue_timeout", n >= 50, 0);
    tick();
    n0 = ack_log.size();
    rst = 1;
    tick();
    rst = 0; cpu_req = 0;
    chk("rst_ce", mem_ce, 0);
    chk("rst_cpu_do", cpu_do, 0);
    chk("rst_vid_data", vid_data, 0);
    repeat (8) tick();
    chk("rst_no_ack", ack_log.size(), n0);
    cpu_access(1, 15'h0123, 8'h5C);
    cpu_access(0, 15'h0123, 8'h00);
    chk("post_rst_rd", cpu_do, 8'h5C);

    // Random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (vid_req && seen_vid_ack)       vid_req = 1'($urandom);
      else if (!vid_req)                 vid_req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 40) == 0) vid_req = 0;
      if (cpu_req && seen_cpu_ack)       cpu_req = 1'($urandom);
      else if (!cpu_req)                 cpu_req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 40) == 0) cpu_req = 0;
      vid_addr = rnd_addr(); cpu_addr = rnd_addr();
      cpu_we = 1'($urandom); cpu_di = 8'($urandom);
      rst = ($urandom_range(0, 300) == 0);
    end
    rst = 0; vid_req = 0; cpu_req = 0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
